// File: rtl/instdec_pipe.sv
// rtl/instdec_pipe.sv - registered RV32I/RV64I field/format/immediate decoder with DEPTH-entry output FIFO
// Optional: define INSTDEC_ILLEGAL_EN to flag unsupported opcodes and non-32-bit encodings on out_illegal.
module instdec_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_func3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_func7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_INV = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push, pop;
    entry_t          dec;
    entry_t          head;
    logic [2:0]      dec_fmt;
    logic [31:0]     imm32;

    always_comb begin
        dec_fmt = FMT_INV;
        unique case (in_inst[6:0])
            7'b0110011:                                     dec_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
            7'b0100011:                                     dec_fmt = FMT_S;
            7'b1100011:                                     dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
            7'b1101111:                                     dec_fmt = FMT_J;
            default:                                        dec_fmt = FMT_INV;
        endcase
`ifdef INSTDEC_ILLEGAL_EN
        if (in_inst[1:0] != 2'b11) begin
            dec_fmt = FMT_INV;
        end
`endif
    end

    // Immediates are assembled at 32 bits, then sign-extended to XLEN by the signed size cast.
    always_comb begin
        imm32 = '0;
        unique case (dec_fmt)
            FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            FMT_U:   imm32 = {in_inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec.pc   = in_pc;
        dec.inst = in_inst;
        dec.fmt  = dec_fmt;
        dec.imm  = XLEN'($signed(imm32));
`ifdef INSTDEC_ILLEGAL_EN
        dec.illegal = (dec_fmt == FMT_INV);
`else
        dec.illegal = 1'b0;
`endif
    end

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the data outputs read zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= dec;
            end
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_pc      = head.pc;
    assign out_opcode  = head.inst[6:0];
    assign out_rd      = head.inst[11:7];
    assign out_func3   = head.inst[14:12];
    assign out_rs1     = head.inst[19:15];
    assign out_rs2     = head.inst[24:20];
    assign out_func7   = head.inst[31:25];
    assign out_fmt     = head.fmt;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_instdec_pipe.sv
// tb/tb_instdec_pipe.sv - directed self-checking bench for instdec_pipe (XLEN=32, DEPTH=2)
`timescale 1ns/100ps
module tb_instdec_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_func3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_func7;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_illegal;

    int n_chk = 0;
    int n_bad = 0;

`ifdef INSTDEC_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    instdec_pipe #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_func3(out_func3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func7(out_func7),
        .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Single beat with out_ready=1; head checked one edge after acceptance, popped on the following edge.
    task automatic push_check(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [2:0] fmt, input logic [31:0] imm, input logic ill);
        @(negedge clk);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_pc"},    64'(out_pc), 64'(pc));
        check({tag, "_fmt"},   64'(out_fmt), 64'(fmt));
        check({tag, "_imm"},   64'(out_imm), 64'(imm));
        check({tag, "_ill"},   64'(out_illegal), 64'(ill));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc",    64'(out_pc), 64'd0);
        check("rst_out_fmt",   64'(out_fmt), 64'd0);
        check("rst_out_imm",   64'(out_imm), 64'd0);
        check("rst_out_rd",    64'(out_rd), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  64'(in_ready), 64'd1);

        // addi x1,x0,-1
        push_check("addi", 32'hFFF00093, 32'h100, 3'd1, 32'hFFFFFFFF, 1'b0);
        check("addi_opcode", 64'(out_opcode), 64'h13);
        check("addi_rd",     64'(out_rd), 64'd1);
        check("addi_rs1",    64'(out_rs1), 64'd0);

        // add x3,x1,x2
        push_check("add", 32'h002081B3, 32'h104, 3'd0, 32'h0, 1'b0);
        check("add_rd",    64'(out_rd), 64'd3);
        check("add_rs1",   64'(out_rs1), 64'd1);
        check("add_rs2",   64'(out_rs2), 64'd2);
        check("add_func7", 64'(out_func7), 64'd0);

        push_check("jalneg", 32'hFFDFF06F, 32'h108, 3'd5, 32'hFFFFFFFC, 1'b0);

        // back-to-back sw / beq / lui with out_ready=1
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h0020A423; in_pc = 32'h110;
        @(negedge clk);
        check("b2b_sw_fmt", 64'(out_fmt), 64'd2);
        check("b2b_sw_imm", 64'(out_imm), 64'd8);
        in_inst = 32'hFE000EE3; in_pc = 32'h114;
        @(negedge clk);
        check("b2b_beq_fmt", 64'(out_fmt), 64'd3);
        check("b2b_beq_imm", 64'(out_imm), 64'hFFFFFFFC);
        in_inst = 32'h123452B7; in_pc = 32'h118;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_lui_fmt", 64'(out_fmt), 64'd4);
        check("b2b_lui_imm", 64'(out_imm), 64'h12345000);
        check("b2b_lui_rd",  64'(out_rd), 64'd5);
        check("b2b_lui_pc",  64'(out_pc), 64'h118);
        @(negedge clk);
        check("b2b_drained", 64'(out_valid), 64'd0);

        // backpressure: three beats into a 2-deep FIFO
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h200;
        @(negedge clk);
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        in_inst = 32'h0020A423; in_pc = 32'h204;
        @(negedge clk);
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        check("bp_head_a",       64'(out_pc), 64'h200);
        in_inst = 32'h008000EF; in_pc = 32'h208;
        @(negedge clk);
        check("bp_still_full",   64'(in_ready), 64'd0);
        check("bp_head_a_held",  64'(out_pc), 64'h200);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_head_b",       64'(out_pc), 64'h204);
        check("bp_head_b_fmt",   64'(out_fmt), 64'd2);
        check("bp_ready_again",  64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_head_c",       64'(out_pc), 64'h208);
        check("bp_head_c_fmt",   64'(out_fmt), 64'd5);
        check("bp_head_c_imm",   64'(out_imm), 64'd8);
        @(negedge clk);
        check("bp_no_dup",       64'(out_valid), 64'd0);

        // flush with two entries buffered and a beat on the input
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h300;
        @(negedge clk);
        in_pc = 32'h304;
        @(negedge clk);
        check("fl_full", 64'(in_ready), 64'd0);
        in_pc = 32'h308; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready",  64'(in_ready), 64'd1);
        @(negedge clk);
        check("fl_beat_gone", 64'(out_valid), 64'd0);

        // flush while not full: accepted-looking beat must still be discarded
        in_valid = 1'b1; in_pc = 32'h30C; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl2_beat_gone", 64'(out_valid), 64'd0);
        push_check("post_flush", 32'h00000297, 32'h310, 3'd4, 32'h0, 1'b0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h400;
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_before", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #0.5;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_pc",    64'(out_pc), 64'd0);
        #0.5 rst_n = 1'b1;
        push_check("mr_after", 32'h0020A423, 32'h404, 3'd2, 32'd8, 1'b0);

        // unsupported encodings
        push_check("zero_inst", 32'h00000000, 32'h500, 3'd7, 32'h0, ILL_EN);
        push_check("unk_op",    32'h0000007F, 32'h504, 3'd7, 32'h0, ILL_EN);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
